// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory fetch port.
package imem_pkg;

    // Sequencer states: clear the storage, then serve fetches.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default instruction returned on errors and written by the clear.
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    // Width of a word index able to address `depth` words (at least 1 bit).
    function automatic int idx_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry first-word-fallthrough response FIFO with flush.
module imem_rsp_fifo #(
    parameter int           W         = 33,
    parameter logic [W-1:0] EMPTY_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] entry_q [2];
    logic         rd_q;
    logic         wr_q;
    logic [1:0]   count_q;

    // Entry storage: written on push, never reset.
    // NOTE: storage arrays carry no reset; validity is tracked by count_q,
    // so resetting them would only add fan-out on rst_n for nothing.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            entry_q[wr_q] <= din;
        end
    end

    // Pointers and occupancy; flush empties the FIFO at the next edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) wr_q <= ~wr_q;
            if (pop)  rd_q <= ~rd_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign dout  = (count_q == 2'd0) ? EMPTY_VAL : entry_q[rd_q];

endmodule

// File: rtl/imem_fetch_port.sv
// Writable instruction memory with valid/ready fetch, one-cycle read stage,
// buffered responses, flush and a hardware clear sequencer.
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 64,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic              rsp_err,
    input  logic              flush,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              init_done
);

    localparam int IW = idx_w(DEPTH);
    localparam int XW = ADDR_W - 2;

    state_t            state_q, state_d;
    logic [IW-1:0]     cnt_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [XW-1:0]     req_idx, prog_idx;
    logic              req_bad, prog_ok, bypass, accept;
    logic [DATA_W-1:0] rd_data;

    logic              s1_valid, s1_err;
    logic [DATA_W-1:0] s1_data;
    logic [1:0]        fifo_count, occ;
    logic              pop;

    assign req_idx  = req_addr[ADDR_W-1:2];
    assign prog_idx = prog_addr[ADDR_W-1:2];
    assign req_bad  = (req_addr[1:0] != 2'b00) || (req_idx >= XW'(DEPTH));
    assign prog_ok  = (state_q == RUN) && prog_we && (prog_addr[1:0] == 2'b00)
                      && (prog_idx < XW'(DEPTH));

    // Write-first: a same-cycle program write to the fetched word wins.
    assign bypass  = prog_ok && (prog_idx == req_idx);
    assign rd_data = bypass ? prog_data : mem[req_idx[IW-1:0]];

    // Single write port: clear sequencer during INIT, program port in RUN.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[cnt_q] <= NOP_WORD;
        end else if (prog_ok) begin
            mem[prog_idx[IW-1:0]] <= prog_data;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= INIT;
        else        state_q <= state_d;
    end

    // Next state: leave INIT once the last word has been cleared.
    // NOTE: state_d gets a default first so no path through the block leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (state_q == INIT && cnt_q == IW'(DEPTH - 1)) state_d = RUN;
    end

    // Clear counter walks every word once while in INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt_q <= '0;
        else if (state_q == INIT)  cnt_q <= cnt_q + 1'b1;
    end

    assign init_done = (state_q == RUN);
    assign pop       = rsp_valid && rsp_ready;
    assign occ       = fifo_count + {1'b0, s1_valid};
    assign req_ready = (state_q == RUN) && !flush && ((occ < 2'd2) || pop);
    assign accept    = req_valid && req_ready;

    // Read stage: captures data (or NOP on error) for each accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= NOP_WORD;
        end else begin
            s1_valid <= accept && !flush;
            if (accept) begin
                s1_err  <= req_bad;
                s1_data <= req_bad ? NOP_WORD : rd_data;
            end
        end
    end

    imem_rsp_fifo #(
        .W         (DATA_W + 1),
        .EMPTY_VAL ({1'b0, NOP_WORD})
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (s1_valid && !flush),
        .din   ({s1_err, s1_data}),
        .pop   (pop),
        .dout  ({rsp_err, rsp_instr}),
        .count (fifo_count)
    );

    assign rsp_valid = (fifo_count != 2'd0);

endmodule

// File: tb/tb_imem_fetch_port.sv
// Scoreboard bench for imem_fetch_port with default parameters.
module tb_imem_fetch_port;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        flush = 1'b0;
    logic        prog_we = 1'b0;
    logic [31:0] prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        init_done;

    imem_fetch_port dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] instr;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] model [64];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    logic        lat_chk = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: handshakes seen at the negedge complete at the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    mon_e = q.pop_front();
                    check("rsp", {rsp_err, rsp_instr}, {mon_e.err, mon_e.instr});
                    if (lat_chk) check("latency", 64'(cyc + 1 - mon_e.acc), 64'd2);
                end
            end else if (rsp_valid && q.size() > 0) begin
                check("hold", {rsp_err, rsp_instr}, {q[0].err, q[0].instr});
            end
            if (prog_we && !bad_addr(prog_addr)) model[prog_addr[7:2]] = prog_data;
            if (flush) begin
                q.delete();
            end else if (req_valid && req_ready) begin
                mon_e.err   = bad_addr(req_addr);
                mon_e.instr = mon_e.err ? NOP : model[req_addr[7:2]];
                mon_e.acc   = cyc + 1;
                q.push_back(mon_e);
                acc_cnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_instr", rsp_instr, NOP);
        check("rst_rsp_err",   rsp_err,   0);
        check("rst_init_done", init_done, 0);
    endtask

    task automatic wait_init();
        int n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("init_len", 64'(n), 64'd64);
        check("init_done", init_done, 1);
    endtask

    task automatic issue(input logic [31:0] a);
        int   n = 0;
        logic acc = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("issue_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic prog(input logic [31:0] a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step(1);
        prog_we   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            step(1);
            n++;
        end
        check("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int c0, a0;
        for (int i = 0; i < 64; i++) model[i] = NOP;

        // Reset and first clear sequence.
        step(2);
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();

        // Fresh memory reads back as NOP.
        rsp_ready = 1'b1;
        issue(32'h00);
        issue(32'h04);
        issue(32'hFC);
        drain();

        // Program and fetch back-to-back at full rate.
        prog(32'h0, 32'h8C08_0008);
        prog(32'h4, 32'h2009_0004);
        prog(32'h8, 32'h8D29_0010);
        prog(32'hC, 32'h1189_0005);
        lat_chk = 1'b1;
        c0 = cyc;
        issue(32'h0);
        issue(32'h4);
        issue(32'h8);
        issue(32'hC);
        check("throughput", 64'(cyc - c0), 64'd4);
        drain();
        lat_chk = 1'b0;

        // Backpressure: only two outstanding while the consumer stalls.
        rsp_ready = 1'b0;
        a0 = acc_cnt;
        issue(32'h0);
        issue(32'h4);
        req_valid = 1'b1;
        req_addr  = 32'h8;
        step(3);
        check("stall_accepts", 64'(acc_cnt - a0), 64'd2);
        @(negedge clk);
        check("stall_req_ready", req_ready, 0);
        check("stall_rsp_valid", rsp_valid, 1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        issue(32'h8);
        issue(32'hC);
        drain();
        check("stall_total", 64'(acc_cnt - a0), 64'd4);

        // Errors and dropped program writes.
        issue(32'h2);
        issue(32'h100);
        drain();
        prog(32'h101, 32'h1234_5678);
        prog(32'h11,  32'hCAFE_F00D);
        issue(32'h0);
        issue(32'h10);
        drain();

        // Same-cycle write and fetch of word 5.
        prog_we   = 1'b1;
        prog_addr = 32'h14;
        prog_data = 32'hDEAD_BEEF;
        issue(32'h14);
        prog_we   = 1'b0;
        issue(32'h14);
        drain();

        // Flush with two outstanding.
        rsp_ready = 1'b0;
        issue(32'h0);
        issue(32'h4);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        @(negedge clk);
        check("flush_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_rsp_valid", rsp_valid, 0);
        rsp_ready = 1'b1;
        step(3);
        check("flush_quiet", rsp_valid, 0);

        // Reset mid-stream: outstanding lost, clear runs again.
        rsp_ready = 1'b0;
        issue(32'h0);
        issue(32'h4);
        #3;
        rst_n = 1'b0;
        q.delete();
        for (int i = 0; i < 64; i++) model[i] = NOP;
        #1;
        check_reset();
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();
        rsp_ready = 1'b1;
        issue(32'h0);
        issue(32'h4);
        drain();

        check("q_end", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_port.md
# imem_fetch_port

Parametrised, writable instruction memory with a valid/ready fetch interface, a buffered one-cycle-latency read path and a hardware clear sequencer. It sits between the fetch stage and instruction storage. It adds four things over a combinational ROM lookup: backpressure, load-time programming, flush, and explicit errors for bad addresses.

## Interface
- `DATA_W`, 32, instruction width
- `ADDR_W`, 32, byte-address width
- `DEPTH`, 64, number of instruction words (≥2, power of two not required)
- `NOP_WORD`, 32'h0000_0000, word returned on error and written by the clear sequencer
- `clk` in 1, single clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `req_valid` in 1, fetch request valid
- `req_ready` out 1, fetch request accepted when both high
- `req_addr` in ADDR_W, byte address of instruction
- `rsp_valid` out 1, response valid
- `rsp_ready` in 1, consumer accepts response
- `rsp_instr` out DATA_W, fetched instruction
- `rsp_err` out 1, misaligned or out-of-range request
- `flush` in 1, discard in-flight and buffered responses
- `prog_we` in 1, program-port write enable
- `prog_addr` in ADDR_W, program byte address (word index = `prog_addr[..:2]`)
- `prog_data` in DATA_W, program data
- `init_done` out 1, clear sequence finished

## Operation
- FSM states are INIT and RUN. Reset forces INIT with the clear counter at 0.
- INIT: writes `NOP_WORD` to word `cnt` each cycle, `cnt` 0→DEPTH-1, then goes to RUN. `req_ready`=0 and `prog_we` is ignored throughout INIT.
- RUN: stays in RUN until reset.
- Word index = `req_addr[ADDR_W-1:2]`.
- Error if `req_addr[1:0]`≠0 or index ≥ DEPTH. The error response has `rsp_err`=1 and `rsp_instr`=`NOP_WORD`, and the memory is not read.
- Read stage: one register `s1_valid`/`s1_data`/`s1_err`, loaded on request acceptance.
- Response buffer: 2-entry FIFO. `s1` enters the FIFO the cycle after acceptance. Output is first-word-fallthrough: `rsp_valid` = FIFO non-empty.
- `occ` = fifo_count + s1_valid, range 0..2.
- `req_ready` = RUN & !flush & (occ<2 | (rsp_valid & rsp_ready)). This is a combinational path from `rsp_ready`, and it is intentional.
- Program writes with an out-of-range or misaligned `prog_addr` are dropped silently.
- Same-cycle program write and fetch accept to the same word: the fetch returns the new `prog_data` (write-first).
- `flush`: clears `s1_valid` and empties the FIFO at the next edge, and `req_ready`=0 in that cycle. A request presented during flush is not accepted. A FIFO pop in the flush cycle is still a completed handshake.
- Responses stay in request order. No response is ever dropped except by flush or reset.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_instr`=`NOP_WORD`, `rsp_err`=0, `init_done`=0. Memory contents are undefined until INIT completes.
- INIT lasts exactly DEPTH cycles after `rst_n` rises. `init_done` and `req_ready` go high in the same cycle, and `init_done` is then held until reset.
- Latency: a request accepted at edge N gives `rsp_valid` high after edge N+1.
- Throughput: 1 request/cycle sustained while `rsp_ready`=1.
- Backpressure: `rsp_ready`=0 stalls after 2 outstanding. `rsp_instr`/`rsp_err` are held stable while `rsp_valid` & !`rsp_ready`.
- Reset mid-operation: all outstanding responses are lost, and INIT restarts from 0. Program writes made before the reset are overwritten by the clear.

## Structure
- Package `imem_pkg`: state enum {INIT, RUN}, `NOP_WORD` default, and a word-index helper function for `DEPTH`-derived index width.
- Sub-module `imem_rsp_fifo`: 2-entry FWFT FIFO of {err, instr}, with flush, count output and asynchronous active-low reset.
- Storage is a plain register array of DEPTH×DATA_W with one write port (muxed between INIT and prog) and one read port.

## Test plan
- Reset release, DEPTH=64: `req_ready` is 0 for 64 cycles, then 1 with `init_done`=1. Fetching 0x00, 0x04 and 0xFC returns 0x0000_0000 with err=0.
- Program words 0–3 with 0x8C080008, 0x20090004, 0x8D290010, 0x11890005. Back-to-back fetches 0x0–0xC with `rsp_ready`=1 return them in order, one per cycle, at latency 1.
- Hold `rsp_ready`=0 and issue 4 requests: only 2 are accepted and `req_ready` drops. Release: the remaining 2 are accepted, the order is preserved and the data stays stable while stalled.
- Fetch 0x2 gives err=1 with NOP. Fetch 0x100 (index 64) gives err=1 with NOP. `prog_we` to 0x101 leaves memory unchanged.
- Same-cycle `prog_we` word 5 = 0xDEADBEEF with fetch 0x14 returns 0xDEADBEEF.
- Flush with 2 outstanding: `rsp_valid`=0 the next cycle and no stale response appears. Asserting `rst_n`=0 mid-stream gives all outputs at reset values and a full 64-cycle INIT again.
